// File: rtl/xy_mod2_master.sv
// rtl/xy_mod2_master.sv - bus initiator: writes x,y to the xy-modulo peripheral and reads back x % (x - y)
// Optional divisor-zero shortcut enabled by defining XY_ZERO_CHECK_EN.
module xy_mod2_master #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32,
  parameter int SETTLE = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  result,
  output logic              err,
  output logic [DATA_W-1:0] BUS_D,
  output logic [1:0]        BUS_ADDR,
  output logic              BUS_W,
  output logic              BUS_R,
  output logic              BUS_E,
  input  logic [RES_W-1:0]  BUS_OUT
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_X, ST_WR_Y, ST_SETTLE, ST_RD_REQ, ST_RD_CAP, ST_DONE, ST_ZCHK
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] y_q;
  logic [3:0]        cnt;
  logic              zero_div;

  logic              busy_d, done_d, bus_w_d, bus_r_d;
  logic [1:0]        addr_d;
  logic [DATA_W-1:0] d_d;

`ifdef XY_ZERO_CHECK_EN
  assign zero_div = (x_in == y_in);
`else
  assign zero_div = 1'b0;
`endif

  // state and all outputs are registered; outputs are derived from the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      y_q      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
      BUS_D    <= '0;
      BUS_ADDR <= '0;
      BUS_W    <= 1'b0;
      BUS_R    <= 1'b0;
      BUS_E    <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= busy_d;
      done     <= done_d;
      BUS_D    <= d_d;
      BUS_ADDR <= addr_d;
      BUS_W    <= bus_w_d;
      BUS_R    <= bus_r_d;
      BUS_E    <= bus_w_d | bus_r_d;
      if (state == ST_IDLE && start)
        y_q <= y_in;
      if (state_nxt == ST_SETTLE && state != ST_SETTLE)
        cnt <= SETTLE_LOAD;
      else if (state == ST_SETTLE)
        cnt <= cnt - 4'd1;
      if (state == ST_RD_CAP) begin
        result <= BUS_OUT;
        err    <= 1'b0;
      end else if (state == ST_ZCHK) begin
        result <= '0;
        err    <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = zero_div ? ST_ZCHK : ST_WR_X;
      ST_WR_X:   state_nxt = ST_WR_Y;
      ST_WR_Y:   state_nxt = (SETTLE == 0) ? ST_RD_REQ : ST_SETTLE;
      ST_SETTLE: if (cnt == 4'd0) state_nxt = ST_RD_REQ;
      ST_RD_REQ: state_nxt = ST_RD_CAP;
      ST_RD_CAP: state_nxt = ST_DONE;
      ST_ZCHK:   state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // WR_X is only entered from IDLE, so x is taken straight from the accept-cycle input
  always_comb begin
    busy_d  = (state_nxt != ST_IDLE);
    done_d  = (state_nxt == ST_DONE);
    bus_w_d = 1'b0;
    bus_r_d = 1'b0;
    addr_d  = 2'd0;
    d_d     = '0;
    case (state_nxt)
      ST_WR_X: begin
        bus_w_d = 1'b1;
        d_d     = x_in;
      end
      ST_WR_Y: begin
        bus_w_d = 1'b1;
        addr_d  = 2'd1;
        d_d     = y_q;
      end
      ST_RD_REQ: begin
        bus_r_d = 1'b1;
        addr_d  = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xy_mod2_master.sv
// tb/tb_xy_mod2_master.sv - randomized self-checking bench for xy_mod2_master (SETTLE=1 and SETTLE=0 instances)
module tb_xy_mod2_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;

  logic        busy_a [2];
  logic        done_a [2];
  logic        err_a  [2];
  logic        w_a    [2];
  logic        r_a    [2];
  logic        e_a    [2];
  logic [1:0]  addr_a [2];
  logic [15:0] d_a    [2];
  logic [31:0] res_a  [2];
  logic [31:0] bout   [2];

  logic [15:0] prx [2];
  logic [15:0] pry [2];

  logic [31:0] exp_res [2];
  logic        exp_err [2];

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  xy_mod2_master #(.DATA_W(16), .RES_W(32), .SETTLE(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy_a[0]), .done(done_a[0]), .result(res_a[0]), .err(err_a[0]),
    .BUS_D(d_a[0]), .BUS_ADDR(addr_a[0]), .BUS_W(w_a[0]), .BUS_R(r_a[0]),
    .BUS_E(e_a[0]), .BUS_OUT(bout[0])
  );

  xy_mod2_master #(.DATA_W(16), .RES_W(32), .SETTLE(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy_a[1]), .done(done_a[1]), .result(res_a[1]), .err(err_a[1]),
    .BUS_D(d_a[1]), .BUS_ADDR(addr_a[1]), .BUS_W(w_a[1]), .BUS_R(r_a[1]),
    .BUS_E(e_a[1]), .BUS_OUT(bout[1])
  );

  function automatic logic [31:0] periph_calc(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] dv;
    dv = x - y;
    if (dv == 16'd0) return 32'hFFFF_FFFF;
    return {16'h0, x % dv};
  endfunction

  // peripheral: registers written by the master, read data valid the cycle after the read strobe, noise otherwise
  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (w_a[i] && addr_a[i] == 2'd0) prx[i] <= d_a[i];
      if (w_a[i] && addr_a[i] == 2'd1) pry[i] <= d_a[i];
      if (r_a[i] && addr_a[i] == 2'd2) bout[i] <= periph_calc(prx[i], pry[i]);
      else bout[i] <= $urandom;
    end
  end

  function automatic logic [31:0] ref_result(input int unsigned x, input int unsigned y);
    int unsigned divisor;
    divisor = (x + 65536 - y) % 65536;
    if (divisor == 0) return 32'hFFFF_FFFF;
    return x % divisor;
  endfunction

  // expected {busy, done, BUS_W, BUS_R, BUS_E, BUS_ADDR, BUS_D} in cycle k after a start in cycle 0
  function automatic logic [22:0] exp_bus(input int s, input bit z, input int k,
                                          input logic [15:0] x, input logic [15:0] y);
    logic b, dn, w, r;
    logic [1:0] a;
    logic [15:0] d;
    int done_cyc;
    done_cyc = z ? 2 : 5 + s;
    b  = (k >= 1) && (k <= done_cyc);
    dn = (k == done_cyc);
    w = 1'b0; r = 1'b0; a = 2'd0; d = 16'd0;
    if (!z) begin
      if (k == 1) begin w = 1'b1; d = x; end
      if (k == 2) begin w = 1'b1; a = 2'd1; d = y; end
      if (k == 3 + s) begin r = 1'b1; a = 2'd2; end
    end
    return {b, dn, w, r, w | r, a, d};
  endfunction

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input string tag, input bit hold);
    bit z;
    int s, done_cyc;
    logic [22:0] expv, obs;
`ifdef XY_ZERO_CHECK_EN
    z = (x == y);
`else
    z = 1'b0;
`endif
    @(posedge CLK);
    #1 start = 1'b1; x_in = x; y_in = y;
    @(posedge CLK);
    for (int k = 1; k <= 9; k++) begin
      #1;
      if (!hold || k >= 6) start = 1'b0;
      x_in = 16'($urandom);
      y_in = 16'($urandom);
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        s = (i == 0) ? 1 : 0;
        done_cyc = z ? 2 : 5 + s;
        if (k == done_cyc) begin
          exp_res[i] = z ? 32'd0 : ref_result(x, y);
          exp_err[i] = z;
        end
        expv = exp_bus(s, z, k, x, y);
        obs  = {busy_a[i], done_a[i], w_a[i], r_a[i], e_a[i], addr_a[i], d_a[i]};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL %s bus dut%0d cycle %0d: got %h expected %h", tag, i, k, obs, expv);
        end
        checks++;
        if (res_a[i] !== exp_res[i] || err_a[i] !== exp_err[i]) begin
          errors++;
          $display("FAIL %s result dut%0d cycle %0d: got %h/%b expected %h/%b",
                   tag, i, k, res_a[i], err_a[i], exp_res[i], exp_err[i]);
        end
      end
    end
  endtask

  task automatic test_reset;
    logic [56:0] obs;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    for (int n = 0; n < 2; n++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        obs = {busy_a[i], done_a[i], err_a[i], w_a[i], r_a[i], e_a[i], addr_a[i], d_a[i], res_a[i]};
        checks++;
        if (obs !== 57'd0) begin
          errors++;
          $display("FAIL reset dut%0d phase %0d: got %h expected 0", i, n, obs);
        end
      end
      @(posedge CLK);
      #1 RST = 1'b0;
    end
    exp_res[0] = 32'd0; exp_res[1] = 32'd0;
    exp_err[0] = 1'b0;  exp_err[1] = 1'b0;
  endtask

  task automatic test_plan_ops;
    run_op(16'd10, 16'd3, "op_10_3", 1'b0);
    run_op(16'd100, 16'd40, "op_100_40", 1'b0);
    run_op(16'd5, 16'd9, "op_wrap_5_9", 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++)
      run_op(16'($urandom), 16'($urandom), "random", 1'b0);
  endtask

  task automatic test_start_held;
    run_op(16'd100, 16'd40, "start_held", 1'b1);
  endtask

  task automatic test_zero_divisor;
    run_op(16'd7, 16'd7, "zero_7_7", 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [56:0] obs;
    run_op(16'd1000, 16'd1, "pre_reset", 1'b0);
    @(posedge CLK);
    #1 start = 1'b1; x_in = 16'd50; y_in = 16'd20;
    @(posedge CLK);
    #1 start = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        obs = {busy_a[i], done_a[i], err_a[i], w_a[i], r_a[i], e_a[i], addr_a[i], d_a[i], res_a[i]};
        checks++;
        if (obs !== 57'd0) begin
          errors++;
          $display("FAIL reset_mid dut%0d cycle %0d: got %h expected 0", i, k, obs);
        end
      end
      @(posedge CLK);
    end
    exp_res[0] = 32'd0; exp_res[1] = 32'd0;
    exp_err[0] = 1'b0;  exp_err[1] = 1'b0;
    run_op(16'd9, 16'd4, "after_reset_9_4", 1'b0);
  endtask

  initial begin
    test_reset();
    test_plan_ops();
    test_start_held();
    test_zero_divisor();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
